// File: rtl/act_pkg.sv
// Shared activation-mode encoding for the act_stream datapath.
package act_pkg;

  typedef enum logic [1:0] {
    ACT_PASS  = 2'd0,
    ACT_RELU  = 2'd1,
    ACT_LEAKY = 2'd2,
    ACT_CLIP  = 2'd3
  } act_mode_t;

endpackage

// File: rtl/act_stream_if.sv
// act_stream_if: upstream beat + per-beat controls, downstream beat, statistics.
// The slave modport is the act_stream side; master is the driving/consuming side.
interface act_stream_if
  import act_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 16
) ();

  logic [LANES*DATA_WIDTH-1:0]   in_tensor;
  logic                          in_valid;
  logic                          in_ready;
  logic                          in_last;
  act_mode_t                     mode;
  logic [$clog2(DATA_WIDTH)-1:0] leak_shift;
  logic [DATA_WIDTH-1:0]         clip_max;

  logic [LANES*DATA_WIDTH-1:0]   out_tensor;
  logic                          out_valid;
  logic                          out_ready;
  logic                          out_last;

  logic                          stat_clr;
  logic [31:0]                   stat_zero;
  logic [31:0]                   stat_clip;

  modport slave (
    input  in_tensor, in_valid, in_last, mode, leak_shift, clip_max, out_ready, stat_clr,
    output in_ready, out_tensor, out_valid, out_last, stat_zero, stat_clip
  );

  modport master (
    output in_tensor, in_valid, in_last, mode, leak_shift, clip_max, out_ready, stat_clr,
    input  in_ready, out_tensor, out_valid, out_last, stat_zero, stat_clip
  );

endinterface

// File: rtl/act_lane.sv
// act_lane: one signed element through pass/ReLU/leaky/clip; combinational, no flow control.
// zeroed = forced to 0 (negative input or negative clip bound), clipped = limited to clip_max.
module act_lane
  import act_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic signed [DATA_WIDTH-1:0]         x,
  input  act_mode_t                            mode,
  input  logic        [$clog2(DATA_WIDTH)-1:0] leak_shift,
  input  logic signed [DATA_WIDTH-1:0]         clip_max,
  output logic signed [DATA_WIDTH-1:0]         y,
  output logic                                 zeroed,
  output logic                                 clipped
);

  logic x_neg;
  assign x_neg = x[DATA_WIDTH-1];

  always_comb begin
    y       = x;
    zeroed  = 1'b0;
    clipped = 1'b0;
    case (mode)
      ACT_RELU: begin
        if (x_neg) begin
          y      = '0;
          zeroed = 1'b1;
        end
      end
      ACT_LEAKY: begin
        // Arithmetic shift floors toward -inf, so -1 stays -1.
        if (x_neg) y = x >>> leak_shift;
      end
      ACT_CLIP: begin
        if (clip_max[DATA_WIDTH-1] || x_neg) begin
          y      = '0;
          zeroed = 1'b1;
        end else if (x > clip_max) begin
          y       = clip_max;
          clipped = 1'b1;
        end
      end
      default: y = x;
    endcase
  end

endmodule

// File: rtl/act_stream.sv
// act_stream: LANES-wide activation pipeline (S1 capture, S2 result); 2-cycle latency, 1 beat/cycle.
// Valid/ready backpressure stalls both stages in place; counters only under ACT_STREAM_STATS_EN.
module act_stream
  import act_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  act_stream_if.slave   bus
);

  localparam int SW = $clog2(DATA_WIDTH);
  localparam int TW = LANES * DATA_WIDTH;

  typedef struct packed {
    act_mode_t             mode;
    logic [SW-1:0]         leak_shift;
    logic [DATA_WIDTH-1:0] clip_max;
    logic                  last;
  } meta_t;

  logic             s1_valid, s2_valid;
  logic             s1_load, s2_load;
  logic [TW-1:0]    s1_tensor, s2_tensor, act_tensor;
  meta_t            s1_meta, in_meta;
  logic             s2_last;
  logic [LANES-1:0] act_zeroed, act_clipped;

  // A stage may load when empty or when the stage after it is taking its beat.
  assign s2_load      = !s2_valid || bus.out_ready;
  assign s1_load      = !s1_valid || s2_load;
  assign bus.in_ready = s1_load;

  assign in_meta = '{mode: bus.mode, leak_shift: bus.leak_shift,
                     clip_max: bus.clip_max, last: bus.in_last};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_tensor <= '0;
      s1_meta   <= '0;
    end else if (s1_load) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_tensor <= bus.in_tensor;
        s1_meta   <= in_meta;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    act_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .x          (s1_tensor[i*DATA_WIDTH +: DATA_WIDTH]),
      .mode       (s1_meta.mode),
      .leak_shift (s1_meta.leak_shift),
      .clip_max   (s1_meta.clip_max),
      .y          (act_tensor[i*DATA_WIDTH +: DATA_WIDTH]),
      .zeroed     (act_zeroed[i]),
      .clipped    (act_clipped[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      s2_tensor <= '0;
      s2_last   <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_tensor <= act_tensor;
        s2_last   <= s1_meta.last;
      end
    end
  end

  assign bus.out_valid  = s2_valid;
  assign bus.out_tensor = s2_tensor;
  assign bus.out_last   = s2_last;

`ifdef ACT_STREAM_STATS_EN
  localparam int CW = $clog2(LANES + 1);

  logic [LANES-1:0] s2_zeroed, s2_clipped;
  logic [CW-1:0]    zero_cnt, clip_cnt;
  logic [31:0]      stat_zero_q, stat_clip_q;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [CW-1:0] b);
    logic [32:0] s;
    s = {1'b0, a} + 33'(b);
    return s[32] ? '1 : s[31:0];
  endfunction

  // Flags travel with their beat so counts are credited at the output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_zeroed  <= '0;
      s2_clipped <= '0;
    end else if (s2_load && s1_valid) begin
      s2_zeroed  <= act_zeroed;
      s2_clipped <= act_clipped;
    end
  end

  always_comb begin
    zero_cnt = '0;
    clip_cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      zero_cnt = zero_cnt + CW'(s2_zeroed[i]);
      clip_cnt = clip_cnt + CW'(s2_clipped[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_zero_q <= '0;
      stat_clip_q <= '0;
    end else if (bus.stat_clr) begin
      stat_zero_q <= '0;
      stat_clip_q <= '0;
    end else if (s2_valid && bus.out_ready) begin
      stat_zero_q <= sat_add(stat_zero_q, zero_cnt);
      stat_clip_q <= sat_add(stat_clip_q, clip_cnt);
    end
  end

  assign bus.stat_zero = stat_zero_q;
  assign bus.stat_clip = stat_clip_q;
`else
  logic unused_stats;
  assign unused_stats  = ^{act_zeroed, act_clipped, bus.stat_clr};
  assign bus.stat_zero = '0;
  assign bus.stat_clip = '0;
`endif

endmodule

// File: tb/tb_act_stream.sv
// Randomized scoreboard bench for act_stream: driver pushes model results, negedge monitor compares.
// Honours ACT_STREAM_STATS_EN for the expected counter values.
module tb_act_stream;
  import act_pkg::*;

  localparam int DW = 8;
  localparam int LN = 16;
  localparam int SW = $clog2(DW);
  localparam int TW = DW * LN;
  localparam longint SAT = 64'hFFFF_FFFF;
`ifdef ACT_STREAM_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  typedef struct {
    logic [TW-1:0] t;
    logic          last;
    int            z;
    int            c;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  act_stream_if #(.DATA_WIDTH(DW), .LANES(LN)) bus ();
  act_stream #(.DATA_WIDTH(DW), .LANES(LN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  exp_t   sb[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  int     inflight = 0;
  longint exp_zero = 0;
  longint exp_clip = 0;
  int     rmode = 1;
  bit     clr_rand = 1'b0;
  bit     clr_force = 1'b0;
  bit     hold = 1'b0;
  logic [TW-1:0] held_t;
  logic          held_l;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic chk_vec(input string name, input logic [TW-1:0] act, input logic [TW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference: floor division for leaky, explicit bounds for clip.
  function automatic int ref_lane(input int x, input int m, input int s, input int c,
                                  output int z, output int k);
    z = 0;
    k = 0;
    case (m)
      1: if (x < 0) begin z = 1; return 0; end
      2: if (x < 0) return -(((-x) + (1 << s) - 1) / (1 << s));
      3: begin
        if (c < 0 || x < 0) begin z = 1; return 0; end
        if (x > c) begin k = 1; return c; end
      end
      default: ;
    endcase
    return x;
  endfunction

  function automatic exp_t ref_beat(input logic [TW-1:0] t, input int m, input int s,
                                    input int c, input bit last);
    exp_t e;
    e.t = '0; e.z = 0; e.c = 0; e.last = last;
    for (int i = 0; i < LN; i++) begin
      int x, y, z, k;
      logic [31:0] yv;
      x = $signed(t[i*DW +: DW]);
      y = ref_lane(x, m, s, c, z, k);
      yv = y;
      e.t[i*DW +: DW] = yv[DW-1:0];
      e.z += z;
      e.c += k;
    end
    return e;
  endfunction

  function automatic logic [TW-1:0] pack4(input int a, input int b, input int c, input int d,
                                          input int fill);
    logic [TW-1:0] r;
    logic [31:0] tmp;
    int v[4];
    v = '{a, b, c, d};
    for (int i = 0; i < LN; i++) begin
      tmp = (i < 4) ? v[i] : fill;
      r[i*DW +: DW] = tmp[DW-1:0];
    end
    return r;
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send_beat(input logic [TW-1:0] t, input int m, input int s, input int c,
                           input bit last);
    logic [31:0] mv, sv, cv;
    int w;
    mv = m; sv = s; cv = c; w = 0;
    bus.in_tensor  = t;
    bus.mode       = act_mode_t'(mv[1:0]);
    bus.leak_shift = sv[SW-1:0];
    bus.clip_max   = cv[DW-1:0];
    bus.in_last    = last;
    bus.in_valid   = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      w++;
      if (w > 300) begin
        n_cmp++; n_bad++;
        $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, expected acceptance", w);
        bus.in_valid = 1'b0;
        return;
      end
    end
    sb.push_back(ref_beat(t, m, s, c, last));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: got %0d beats outstanding, expected 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic send_dir(input logic [TW-1:0] t, input int m, input int s, input int c,
                          input bit last);
    drain();
    send_beat(t, m, s, c, last);
    @(negedge clk); chk("latency_c1_out_valid", bus.out_valid, 0);
    @(negedge clk); chk("latency_c2_out_valid", bus.out_valid, 1);
    @(posedge clk); #1;
  endtask

  task automatic rand_beat(input bit last);
    logic [TW-1:0] t;
    logic [31:0] r;
    for (int i = 0; i < LN; i++) begin
      r = $urandom;
      t[i*DW +: DW] = r[DW-1:0];
    end
    send_beat(t, int'($urandom_range(0, 3)), int'($urandom_range(0, DW - 1)),
              int'($urandom_range(0, 159)) - 32, last);
  endtask

  initial begin
    bus.out_ready = 1'b0;
    bus.stat_clr  = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0:       bus.out_ready = 1'b0;
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      bus.stat_clr = clr_force | (clr_rand && ($urandom_range(0, 15) == 0));
    end
  end

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      inflight = 0;
      exp_zero = 0;
      exp_clip = 0;
      hold     = 1'b0;
    end else begin
      chk("stat_zero", bus.stat_zero, STATS_EN ? exp_zero : 0);
      chk("stat_clip", bus.stat_clip, STATS_EN ? exp_clip : 0);
      chk("in_ready", bus.in_ready, (inflight == 2 && !bus.out_ready) ? 0 : 1);
      if (hold) begin
        chk("stall_out_valid", bus.out_valid, 1);
        chk_vec("stall_out_tensor", bus.out_tensor, held_t);
        chk("stall_out_last", bus.out_last, held_l);
      end
      hold   = bus.out_valid && !bus.out_ready;
      held_t = bus.out_tensor;
      held_l = bus.out_last;
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_beat: got tensor %h, expected no output", bus.out_tensor);
        end else begin
          e = sb.pop_front();
          chk_vec("out_tensor", bus.out_tensor, e.t);
          chk("out_last", bus.out_last, e.last);
          exp_zero = (exp_zero + e.z > SAT) ? SAT : exp_zero + e.z;
          exp_clip = (exp_clip + e.c > SAT) ? SAT : exp_clip + e.c;
        end
        inflight--;
      end
      if (bus.stat_clr) begin
        exp_zero = 0;
        exp_clip = 0;
      end
      if (bus.in_valid && bus.in_ready) inflight++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected completion within time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_tensor  = '0;
    bus.in_last    = 1'b0;
    bus.mode       = ACT_PASS;
    bus.leak_shift = '0;
    bus.clip_max   = '0;

    #2 rst_n = 1'b0;
    #10;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk_vec("rst_out_tensor", bus.out_tensor, '0);
    chk("rst_stat_zero", bus.stat_zero, 0);
    chk("rst_stat_clip", bus.stat_clip, 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", bus.in_ready, 1);

    rmode = 1;
    send_dir(pack4(-128, -1, 0, 127, 0), 1, 0, 0, 1'b0);
    send_dir(pack4(-8, -1, -7, 5, 0), 2, 2, 0, 1'b0);
    send_dir(pack4(-3, 4, 6, 100, 0), 3, 0, 6, 1'b0);
    send_dir(pack4(-3, 4, 6, 100, 0), 3, 0, -1, 1'b1);

    drain();
    send_beat(pack4(-5, -5, -5, -5, -5), 0, 0, 0, 1'b0);
    send_beat(pack4(-5, -5, -5, -5, -5), 1, 0, 0, 1'b0);
    send_beat(pack4(-5, -5, -5, -5, -5), 0, 0, 0, 1'b0);
    send_beat(pack4(-5, -5, -5, -5, -5), 1, 0, 0, 1'b1);
    drain();

    clr_force = 1'b1;
    repeat (2) @(negedge clk);
    clr_force = 1'b0;
    @(posedge clk); #1;

    rmode = 2;
    for (int i = 0; i < 10; i++) rand_beat(i == 9);
    drain();

    clr_rand = 1'b1;
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      rand_beat($urandom_range(0, 3) == 0);
    end
    drain();
    clr_rand = 1'b0;
    send_dir(pack4(1, 1, 1, 1, 1), 0, 0, 0, 1'b0);

    rmode = 0;
    repeat (2) begin @(posedge clk); #1; end
    send_beat(pack4(10, -20, 30, -40, 3), 1, 0, 0, 1'b0);
    send_beat(pack4(50, -60, 70, -80, 4), 2, 1, 0, 1'b1);
    #2;
    chk("full_out_valid", bus.out_valid, 1);
    chk("full_in_ready", bus.in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", bus.out_valid, 0);
    chk_vec("async_rst_out_tensor", bus.out_tensor, '0);
    chk("async_rst_out_last", bus.out_last, 0);
    repeat (2) @(negedge clk);
    rmode = 1;
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("no_stale_out_valid", bus.out_valid, 0);
    end
    @(posedge clk); #1;
    send_dir(pack4(-1, 2, -3, 4, 7), 1, 0, 0, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
